// File: rtl/run_trace_monitor.sv
// Run monitor: ends a run on halt (inst==0) or cycle timeout, then streams PC/REG/MEM records.
// Optional macro TRACE_PC_EN: emit PC records (with back-pressure on the machine) during RUN.
`timescale 1ns/1ps
module run_trace_monitor #(
   parameter int          DATA_W     = 32,
   parameter int          NUM_REGS   = 32,
   parameter int          REG_AW     = 5,
   parameter int unsigned MEM_BASE   = 32'h4000,
   parameter int          MEM_WORDS  = 4,
   parameter int          MAX_CYCLES = 64,
   parameter int          CNT_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] pc,
   input  logic [31:0]       inst,
   output logic              cpu_stall,
   output logic [REG_AW-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic [DATA_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        out_tag,
   output logic [DATA_W-1:0] out_data,
   output logic              done,
   output logic [1:0]        reason,
   output logic [CNT_W-1:0]  cycles
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_DUMP_REGS,
      S_DUMP_MEM,
      S_DONE
   } state_t;

   localparam logic [1:0]        TAG_PC      = 2'd0;
   localparam logic [1:0]        TAG_REG     = 2'd1;
   localparam logic [1:0]        TAG_MEM     = 2'd2;
   localparam logic [1:0]        RSN_HALT    = 2'd1;
   localparam logic [1:0]        RSN_TIMEOUT = 2'd2;
   localparam logic [CNT_W-1:0]  LAST_CYCLE  = CNT_W'(MAX_CYCLES - 1);
   localparam logic [REG_AW-1:0] LAST_REG    = REG_AW'(NUM_REGS - 1);
   localparam logic [DATA_W-1:0] FIRST_MEM   = DATA_W'(MEM_BASE);
   localparam logic [DATA_W-1:0] LAST_MEM    = DATA_W'(MEM_BASE + MEM_WORDS - 1);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cycles_q, cycles_d;
   logic [REG_AW-1:0]  rf_addr_q, rf_addr_d;
   logic [DATA_W-1:0]  mem_addr_q, mem_addr_d;
   logic [1:0]         reason_q, reason_d;
   logic               exec;

`ifndef TRACE_PC_EN
   logic unused_pc;
   assign unused_pc = ^pc;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cycles_q   <= '0;
         rf_addr_q  <= '0;
         mem_addr_q <= '0;
         reason_q   <= 2'd0;
      end else begin
         state_q    <= state_d;
         cycles_q   <= cycles_d;
         rf_addr_q  <= rf_addr_d;
         mem_addr_q <= mem_addr_d;
         reason_q   <= reason_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cycles_d   = cycles_q;
      rf_addr_d  = rf_addr_q;
      mem_addr_d = mem_addr_q;
      reason_d   = reason_q;
      out_valid  = 1'b0;
      out_tag    = TAG_PC;
      out_data   = '0;
      cpu_stall  = 1'b1;
      exec       = 1'b0;

      case (state_q)
         S_IDLE: state_d = S_RUN;

         S_RUN: begin
`ifdef TRACE_PC_EN
            out_valid = 1'b1;
            out_tag   = TAG_PC;
            out_data  = pc;
            cpu_stall = !out_ready;
            exec      = out_ready;
`else
            cpu_stall = 1'b0;
            exec      = 1'b1;
`endif
            // Halt is tested first so it wins over a coincident timeout.
            if (exec) begin
               cycles_d = cycles_q + CNT_W'(1);
               if (inst == 32'd0) begin
                  reason_d  = RSN_HALT;
                  rf_addr_d = '0;
                  state_d   = S_DUMP_REGS;
               end else if (cycles_q == LAST_CYCLE) begin
                  reason_d  = RSN_TIMEOUT;
                  rf_addr_d = '0;
                  state_d   = S_DUMP_REGS;
               end
            end
         end

         S_DUMP_REGS: begin
            out_valid = 1'b1;
            out_tag   = TAG_REG;
            out_data  = rf_data;
            if (out_ready) begin
               if (rf_addr_q == LAST_REG) begin
                  mem_addr_d = FIRST_MEM;
                  state_d    = S_DUMP_MEM;
               end else begin
                  rf_addr_d = rf_addr_q + REG_AW'(1);
               end
            end
         end

         S_DUMP_MEM: begin
            out_valid = 1'b1;
            out_tag   = TAG_MEM;
            out_data  = mem_data;
            if (out_ready) begin
               if (mem_addr_q == LAST_MEM) begin
                  state_d = S_DONE;
               end else begin
                  mem_addr_d = mem_addr_q + DATA_W'(1);
               end
            end
         end

         S_DONE: ;

         default: state_d = S_IDLE;
      endcase

      // The machine runs freely while the monitor itself is held in reset.
      if (reset) begin
         cpu_stall = 1'b0;
      end
   end

   assign rf_addr  = rf_addr_q;
   assign mem_addr = mem_addr_q;
   assign done     = (state_q == S_DONE);
   assign reason   = reason_q;
   assign cycles   = cycles_q;

endmodule

// File: tb/tb_run_trace_monitor.sv
// Directed bench for run_trace_monitor; the bench acts as the machine and as the record consumer.
`timescale 1ns/1ps
module tb_run_trace_monitor;

   localparam int          DATA_W     = 32;
   localparam int          NUM_REGS   = 4;
   localparam int          REG_AW     = 2;
   localparam int unsigned MEM_BASE   = 32'h4000;
   localparam int          MEM_WORDS  = 2;
   localparam int          MAX_CYCLES = 8;
   localparam int          CNT_W      = 16;
   localparam logic [31:0] RF_TAG     = 32'hA000_0000;
   localparam logic [31:0] MEM_XOR    = 32'h5A5A_0000;
   localparam logic [31:0] NOP        = 32'h0000_0013;

   logic              clk = 1'b0;
   logic              reset;
   logic [DATA_W-1:0] pc;
   logic [31:0]       inst;
   logic              cpu_stall;
   logic [REG_AW-1:0] rf_addr;
   logic [DATA_W-1:0] rf_data;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              out_valid;
   logic              out_ready;
   logic [1:0]        out_tag;
   logic [DATA_W-1:0] out_data;
   logic              done;
   logic [1:0]        reason;
   logic [CNT_W-1:0]  cycles;

   logic [31:0] prog [0:15];
   int          pc_idx;
   bit          adv;
   logic [1:0]  rec_tag[$];
   logic [31:0] rec_data[$];
   logic [1:0]  exp_tag[$];
   logic [31:0] exp_data[$];
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   assign pc       = 32'(pc_idx * 4);
   assign inst     = prog[pc_idx & 15];
   assign rf_data  = RF_TAG | 32'(rf_addr);
   assign mem_data = mem_addr ^ MEM_XOR;

   run_trace_monitor #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .REG_AW(REG_AW), .MEM_BASE(MEM_BASE),
      .MEM_WORDS(MEM_WORDS), .MAX_CYCLES(MAX_CYCLES), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .reset(reset), .pc(pc), .inst(inst), .cpu_stall(cpu_stall),
      .rf_addr(rf_addr), .rf_data(rf_data), .mem_addr(mem_addr), .mem_data(mem_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag), .out_data(out_data),
      .done(done), .reason(reason), .cycles(cycles)
   );

   // Machine advances on an edge where stall was low; consumer logs every accepted record.
   task automatic tick(input logic rdy);
      @(negedge clk);
      if (adv) pc_idx++;
      out_ready = rdy;
      #1;
      if (out_valid && out_ready) begin
         rec_tag.push_back(out_tag);
         rec_data.push_back(out_data);
      end
      adv = !cpu_stall;
   endtask

   task automatic load_prog(input int halt_idx);
      for (int i = 0; i < 16; i++) prog[i] = (i == halt_idx) ? 32'd0 : NOP + 32'(i << 12);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      pc_idx = 0;
      adv = 1'b0;
      rec_tag.delete();
      rec_data.delete();
   endtask

   task automatic run_to_done();
      for (int i = 0; i < 200 && done !== 1'b1; i++) tick(1'b1);
   endtask

   task automatic build_exp(input int n_pc);
      exp_tag.delete();
      exp_data.delete();
`ifdef TRACE_PC_EN
      for (int i = 0; i < n_pc; i++) begin
         exp_tag.push_back(2'd0);
         exp_data.push_back(32'(i * 4));
      end
`else
      if (n_pc < 0) exp_tag.push_back(2'd3);
`endif
      for (int i = 0; i < NUM_REGS; i++) begin
         exp_tag.push_back(2'd1);
         exp_data.push_back(RF_TAG | 32'(i));
      end
      for (int i = 0; i < MEM_WORDS; i++) begin
         exp_tag.push_back(2'd2);
         exp_data.push_back(32'(MEM_BASE + 32'(i)) ^ MEM_XOR);
      end
   endtask

   task automatic test_reset();
      load_prog(2);
      out_ready = 1'b1;
      pc_idx = 0;
      adv = 1'b0;
      #2 reset = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      checks++; if (cycles !== 16'd0) begin errors++; $display("FAIL rst_cycles got %0d want 0", cycles); end
      checks++; if (rf_addr !== 2'd0) begin errors++; $display("FAIL rst_rf_addr got %0d want 0", rf_addr); end
      checks++; if (mem_addr !== 32'd0) begin errors++; $display("FAIL rst_mem_addr got %h want 0", mem_addr); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
      checks++; if (reason !== 2'd0) begin errors++; $display("FAIL rst_reason got %0d want 0", reason); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", out_valid); end
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL rst_stall got %b want 0", cpu_stall); end
      @(negedge clk);
      reset = 1'b0;
      #1;
      checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL idle_stall got %b want 1", cpu_stall); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", out_valid); end
   endtask

   task automatic test_halt();
      load_prog(2);
      do_reset();
      run_to_done();
      build_exp(3);
      checks++;
      if (rec_tag.size() !== exp_tag.size()) begin
         errors++; $display("FAIL halt_count got %0d want %0d", rec_tag.size(), exp_tag.size());
      end
      for (int i = 0; i < rec_tag.size() && i < exp_tag.size(); i++) begin
         checks++;
         if (rec_tag[i] !== exp_tag[i] || rec_data[i] !== exp_data[i]) begin
            errors++; $display("FAIL halt_rec%0d got tag %0d data %h want tag %0d data %h", i, rec_tag[i], rec_data[i], exp_tag[i], exp_data[i]);
         end
      end
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_done got %b want 1", done); end
      checks++; if (reason !== 2'd1) begin errors++; $display("FAIL halt_reason got %0d want 1", reason); end
      checks++; if (cycles !== 16'd3) begin errors++; $display("FAIL halt_cycles got %0d want 3", cycles); end
      checks++; if (out_valid !== 1'b0 || cpu_stall !== 1'b1) begin errors++; $display("FAIL halt_done_outs got valid %b stall %b want 0 1", out_valid, cpu_stall); end
   endtask

   task automatic test_timeout();
      load_prog(-1);
      do_reset();
      run_to_done();
      build_exp(MAX_CYCLES);
      checks++;
      if (rec_tag.size() !== exp_tag.size()) begin
         errors++; $display("FAIL tmo_count got %0d want %0d", rec_tag.size(), exp_tag.size());
      end
      for (int i = 0; i < rec_tag.size() && i < exp_tag.size(); i++) begin
         checks++;
         if (rec_tag[i] !== exp_tag[i] || rec_data[i] !== exp_data[i]) begin
            errors++; $display("FAIL tmo_rec%0d got tag %0d data %h want tag %0d data %h", i, rec_tag[i], rec_data[i], exp_tag[i], exp_data[i]);
         end
      end
      checks++; if (reason !== 2'd2) begin errors++; $display("FAIL tmo_reason got %0d want 2", reason); end
      checks++; if (cycles !== 16'd8) begin errors++; $display("FAIL tmo_cycles got %0d want 8", cycles); end
   endtask

   task automatic test_halt_at_limit();
      load_prog(MAX_CYCLES - 1);
      do_reset();
      run_to_done();
      build_exp(MAX_CYCLES);
      checks++;
      if (rec_tag.size() !== exp_tag.size()) begin
         errors++; $display("FAIL lim_count got %0d want %0d", rec_tag.size(), exp_tag.size());
      end
      checks++; if (reason !== 2'd1) begin errors++; $display("FAIL lim_reason got %0d want 1", reason); end
      checks++; if (cycles !== 16'd8) begin errors++; $display("FAIL lim_cycles got %0d want 8", cycles); end
   endtask

   task automatic test_run_backpressure();
      load_prog(4);
      do_reset();
      tick(1'b1);
      tick(1'b1);
      for (int k = 0; k < 3; k++) begin
         tick(1'b0);
`ifdef TRACE_PC_EN
         checks++; if (cpu_stall !== 1'b1) begin errors++; $display("FAIL bp_stall%0d got %b want 1", k, cpu_stall); end
         checks++; if (out_valid !== 1'b1 || out_data !== 32'h8) begin errors++; $display("FAIL bp_pc%0d got valid %b data %h want 1 8", k, out_valid, out_data); end
         checks++; if (cycles !== 16'd2) begin errors++; $display("FAIL bp_cycles%0d got %0d want 2", k, cycles); end
`else
         checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL bp_stall%0d got %b want 0", k, cpu_stall); end
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_valid%0d got %b want 0", k, out_valid); end
         checks++; if (cycles !== 16'(2 + k)) begin errors++; $display("FAIL bp_cycles%0d got %0d want %0d", k, cycles, 2 + k); end
`endif
      end
      run_to_done();
      build_exp(5);
      checks++;
      if (rec_tag.size() !== exp_tag.size()) begin
         errors++; $display("FAIL bp_count got %0d want %0d", rec_tag.size(), exp_tag.size());
      end
      for (int i = 0; i < rec_tag.size() && i < exp_tag.size(); i++) begin
         checks++;
         if (rec_tag[i] !== exp_tag[i] || rec_data[i] !== exp_data[i]) begin
            errors++; $display("FAIL bp_rec%0d got tag %0d data %h want tag %0d data %h", i, rec_tag[i], rec_data[i], exp_tag[i], exp_data[i]);
         end
      end
      checks++; if (cycles !== 16'd5) begin errors++; $display("FAIL bp_final_cycles got %0d want 5", cycles); end
   endtask

   task automatic test_dump_backpressure();
      bit found;
      load_prog(2);
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         tick(1'b1);
         if (rec_tag.size() > 0)
            found = (rec_tag[rec_tag.size()-1] == 2'd1) && (rec_data[rec_data.size()-1] == (RF_TAG | 32'd1));
      end
      checks++; if (!found) begin errors++; $display("FAIL dbp_reach_r1 got not-reached want reached"); end
      for (int k = 0; k < 4; k++) begin
         tick(1'b0);
         checks++; if (rf_addr !== 2'd2) begin errors++; $display("FAIL dbp_addr%0d got %0d want 2", k, rf_addr); end
         checks++;
         if (out_valid !== 1'b1 || out_tag !== 2'd1 || out_data !== (RF_TAG | 32'd2)) begin
            errors++; $display("FAIL dbp_hold%0d got valid %b tag %0d data %h want 1 1 %h", k, out_valid, out_tag, out_data, RF_TAG | 32'd2);
         end
      end
      run_to_done();
      build_exp(3);
      checks++;
      if (rec_tag.size() !== exp_tag.size()) begin
         errors++; $display("FAIL dbp_count got %0d want %0d", rec_tag.size(), exp_tag.size());
      end
      for (int i = 0; i < rec_tag.size() && i < exp_tag.size(); i++) begin
         checks++;
         if (rec_tag[i] !== exp_tag[i] || rec_data[i] !== exp_data[i]) begin
            errors++; $display("FAIL dbp_rec%0d got tag %0d data %h want tag %0d data %h", i, rec_tag[i], rec_data[i], exp_tag[i], exp_data[i]);
         end
      end
   endtask

   task automatic test_reset_mid_mem();
      bit found;
      load_prog(2);
      do_reset();
      found = 1'b0;
      for (int i = 0; i < 50 && !found; i++) begin
         tick(1'b1);
         if (rec_tag.size() > 0) found = (rec_tag[rec_tag.size()-1] == 2'd2);
      end
      checks++; if (!found) begin errors++; $display("FAIL rmm_reach_mem got not-reached want reached"); end
      #2 reset = 1'b1;
      #1;
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmm_done got %b want 0", done); end
      checks++; if (reason !== 2'd0) begin errors++; $display("FAIL rmm_reason got %0d want 0", reason); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmm_valid got %b want 0", out_valid); end
      checks++; if (mem_addr !== 32'd0 || cycles !== 16'd0) begin errors++; $display("FAIL rmm_regs got mem_addr %h cycles %0d want 0 0", mem_addr, cycles); end
      @(negedge clk);
      reset = 1'b0;
      pc_idx = 0;
      adv = 1'b0;
      rec_tag.delete();
      rec_data.delete();
      run_to_done();
      build_exp(3);
      checks++;
      if (rec_tag.size() !== exp_tag.size()) begin
         errors++; $display("FAIL rmm_count got %0d want %0d", rec_tag.size(), exp_tag.size());
      end
      for (int i = 0; i < rec_tag.size() && i < exp_tag.size(); i++) begin
         checks++;
         if (rec_tag[i] !== exp_tag[i] || rec_data[i] !== exp_data[i]) begin
            errors++; $display("FAIL rmm_rec%0d got tag %0d data %h want tag %0d data %h", i, rec_tag[i], rec_data[i], exp_tag[i], exp_data[i]);
         end
      end
      checks++; if (cycles !== 16'd3 || reason !== 2'd1) begin errors++; $display("FAIL rmm_rerun got cycles %0d reason %0d want 3 1", cycles, reason); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      out_ready = 1'b1;
      test_reset();
      test_halt();
      test_timeout();
      test_halt_at_limit();
      test_run_backpressure();
      test_dump_backpressure();
      test_reset_mid_mem();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
